soc_ctrl_rst_seq_gen: RTL and testbench

SOC_CTRL_RST_SEQ_GEN -- requirements
Module: soc_ctrl_rst_seq_gen

---
 rtl/soc_ctrl_rst_seq_gen.sv | 140 ++++++++++++++
 tb/tb_soc_ctrl_rst_seq_gen.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/soc_ctrl_rst_seq_gen.sv
// Ordered per-channel clock-enable/reset release and reverse shutdown,
// gated by a synchronized PLL lock.
module soc_ctrl_rst_seq_gen #(
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                    clk_i,
    input  logic                    arst_i,
    input  logic                    pll_lock_i,
    input  logic                    en_i,
    input  logic [NUM_CH*CNT_W-1:0] delay_i,
    output logic [NUM_CH-1:0]       rst_no,
    output logic [NUM_CH-1:0]       clk_en_o,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    lock_lost_o
);

    localparam int KW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NUM_CH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CH_WAIT,
        S_CH_REL,
        S_RUN,
        S_SH_RST,
        S_SH_CLK
    } state_t;

    state_t                 r_state;
    logic [KW-1:0]          r_k;
    logic [CNT_W-1:0]       r_cnt;
    logic [SYNC_STAGES-1:0] r_sync;
    logic [NUM_CH-1:0]      r_rst_n;
    logic [NUM_CH-1:0]      r_clk_en;
    logic                   r_lock_lost;

    logic                   w_lock_s;
    logic [KW-1:0]          w_k_nxt;
    logic [CNT_W-1:0]       w_dly [NUM_CH];

    assign w_lock_s = r_sync[SYNC_STAGES-1];
    assign w_k_nxt  = r_k + 1'b1;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_dly
        assign w_dly[g] = delay_i[g*CNT_W +: CNT_W];
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            r_state     <= S_IDLE;
            r_k         <= '0;
            r_cnt       <= '0;
            r_sync      <= '0;
            r_rst_n     <= '0;
            r_clk_en    <= '0;
            r_lock_lost <= 1'b0;
        end else begin
            r_sync      <= {r_sync[SYNC_STAGES-2:0], pll_lock_i};
            r_lock_lost <= 1'b0;
            // Lock loss beats every other transition, including en_i=0.
            if (r_state != S_IDLE && !w_lock_s) begin
                r_state     <= S_IDLE;
                r_k         <= '0;
                r_cnt       <= '0;
                r_rst_n     <= '0;
                r_clk_en    <= '0;
                r_lock_lost <= 1'b1;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (en_i && w_lock_s) begin
                            r_state <= S_CH_WAIT;
                            r_k     <= '0;
                            r_cnt   <= w_dly[0];
                        end
                    end
                    S_CH_WAIT: begin
                        if (!en_i) begin
                            r_state <= S_SH_RST;
                            r_k     <= K_LAST;
                        end else if (r_cnt != '0) begin
                            r_cnt <= r_cnt - 1'b1;
                        end else begin
                            r_clk_en[r_k] <= 1'b1;
                            r_state       <= S_CH_REL;
                        end
                    end
                    S_CH_REL: begin
                        if (!en_i) begin
                            r_state <= S_SH_RST;
                            r_k     <= K_LAST;
                        end else begin
                            r_rst_n[r_k] <= 1'b1;
                            if (r_k == K_LAST) begin
                                r_state <= S_RUN;
                            end else begin
                                r_k     <= w_k_nxt;
                                r_cnt   <= w_dly[w_k_nxt];
                                r_state <= S_CH_WAIT;
                            end
                        end
                    end
                    S_RUN: begin
                        if (!en_i) begin
                            r_state <= S_SH_RST;
                            r_k     <= K_LAST;
                        end
                    end
                    S_SH_RST: begin
                        r_rst_n[r_k] <= 1'b0;
                        r_state      <= S_SH_CLK;
                    end
                    S_SH_CLK: begin
                        r_clk_en[r_k] <= 1'b0;
                        if (r_k == '0) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_k     <= r_k - 1'b1;
                            r_state <= S_SH_RST;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign rst_no      = r_rst_n;
    assign clk_en_o    = r_clk_en;
    assign lock_lost_o = r_lock_lost;
    assign done_o      = (r_state == S_RUN);
    assign busy_o      = (r_state == S_CH_WAIT) || (r_state == S_CH_REL) ||
                         (r_state == S_SH_RST)  || (r_state == S_SH_CLK);

endmodule

// File: tb/tb_soc_ctrl_rst_seq_gen.sv
// Scoreboard bench: expected output vectors are queued per cycle from
// the timing rules and compared when that cycle's outputs settle.
module tb_soc_ctrl_rst_seq_gen;

    logic        clk = 1'b0;
    logic        arst;
    logic        lock;
    logic        en;
    logic [31:0] delay;
    logic [3:0]  rst_no;
    logic [3:0]  clk_en;
    logic        busy;
    logic        done;
    logic        lost;
    logic [10:0] obs;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;
    int base  = 0;
    int sc    = 0;

    int dly [4] = '{3, 0, 5, 1};

    typedef struct {
        int          cyc;
        int          sc;
        int          n;
        logic [10:0] v;
    } exp_t;

    exp_t q[$];
    exp_t m_e;

    soc_ctrl_rst_seq_gen #(
        .NUM_CH(4),
        .CNT_W(8),
        .SYNC_STAGES(2)
    ) dut (
        .clk_i(clk),
        .arst_i(arst),
        .pll_lock_i(lock),
        .en_i(en),
        .delay_i(delay),
        .rst_no(rst_no),
        .clk_en_o(clk_en),
        .busy_o(busy),
        .done_o(done),
        .lock_lost_o(lost)
    );

    assign obs = {rst_no, clk_en, busy, done, lost};

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Release schedule when CH_WAIT for channel 0 is entered at edge e.
    function automatic logic [10:0] exp_rel(int n, int e);
        logic [3:0] r;
        logic [3:0] c;
        int t;
        int ce;
        int rn;
        r = '0;
        c = '0;
        t = e;
        for (int k = 0; k < 4; k++) begin
            ce = t + dly[k] + 1;
            rn = ce + 1;
            if (n >= ce) c[k] = 1'b1;
            if (n >= rn) r[k] = 1'b1;
            t = rn;
        end
        return {r, c, (n >= e && n < t), (n >= t), 1'b0};
    endfunction

    // Reverse shutdown when SH_RST for channel 3 is entered at edge s.
    function automatic logic [10:0] exp_sd(int n, int s, logic [3:0] r0,
                                           logic [3:0] c0);
        logic [3:0] r;
        logic [3:0] c;
        r = r0;
        c = c0;
        for (int k = 0; k < 4; k++) begin
            if (n >= s + 2*(3-k) + 1) r[k] = 1'b0;
            if (n >= s + 2*(3-k) + 2) c[k] = 1'b0;
        end
        return {r, c, (n < s + 8), 1'b0, 1'b0};
    endfunction

    task automatic push(input int n, input logic [10:0] v);
        exp_t e;
        e.cyc = base + n;
        e.sc  = sc;
        e.n   = n;
        e.v   = v;
        q.push_back(e);
    endtask

    task automatic start(input int id);
        sc   = id;
        base = cyc;
    endtask

    task automatic wait_n(input int n);
        while (cyc < base + n) @(negedge clk);
    endtask

    task automatic drain(input int budget);
        int b;
        b = budget;
        while (q.size() > 0 && b > 0) begin
            @(negedge clk);
            b--;
        end
        if (q.size() != 0) begin
            chk($sformatf("s%0d_drain_timeout", sc), q.size(), 0);
            q.delete();
        end
    endtask

    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            m_e = q.pop_front();
            if (m_e.cyc < cyc)
                chk($sformatf("s%0d_n%0d_late", m_e.sc, m_e.n),
                    cyc, m_e.cyc);
            else
                chk($sformatf("s%0d_n%0d", m_e.sc, m_e.n),
                    {21'd0, obs}, {21'd0, m_e.v});
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        arst  = 1'b1;
        lock  = 1'b0;
        en    = 1'b0;
        delay = {8'd1, 8'd5, 8'd0, 8'd3};
        repeat (2) @(negedge clk);
        chk("reset_outs", {21'd0, obs}, 32'd0);
        lock = 1'b1;
        en   = 1'b1;
        @(negedge clk);

        // Release from reset: channel 0 wait starts at edge 3.
        arst = 1'b0;
        start(1);
        for (int n = 1; n <= 22; n++) push(n, exp_rel(n, 3));
        drain(60);

        // Ordered shutdown from RUN.
        en = 1'b0;
        start(2);
        for (int n = 1; n <= 10; n++)
            push(n, exp_sd(n, 1, 4'hf, 4'hf));
        drain(30);

        // Lock loss while channel 2 is waiting.
        en = 1'b1;
        start(3);
        for (int n = 1; n <= 12; n++) push(n, exp_rel(n, 1));
        push(13, 11'b000_0000_0001);
        push(14, 11'd0);
        push(15, 11'd0);
        wait_n(10);
        lock = 1'b0;
        drain(30);
        en   = 1'b0;
        lock = 1'b1;
        repeat (4) @(negedge clk);

        // Abort while channel 1 is in CH_REL.
        en = 1'b1;
        start(4);
        for (int n = 1; n <= 7; n++) push(n, exp_rel(n, 1));
        for (int n = 8; n <= 18; n++)
            push(n, exp_sd(n, 8, 4'b0001, 4'b0011));
        wait_n(7);
        en = 1'b0;
        drain(30);

        // Late delay change has no effect on the running count.
        en = 1'b1;
        start(5);
        for (int n = 1; n <= 20; n++) push(n, exp_rel(n, 1));
        wait_n(3);
        delay[7:0] = 8'd200;
        drain(40);

        // Asynchronous reset mid-RUN, then release again.
        chk("s6_pre_done", {31'd0, done}, 32'd1);
        #2;
        arst = 1'b1;
        #1;
        chk("s6_async_clear", {21'd0, obs}, 32'd0);
        delay[7:0] = 8'd3;
        @(negedge clk);
        arst = 1'b0;
        start(6);
        for (int n = 1; n <= 22; n++) push(n, exp_rel(n, 3));
        drain(60);

        // en re-asserted during shutdown is ignored until IDLE; then lock
        // loss and en drop seen on the same edge: lock loss wins.
        en = 1'b0;
        start(7);
        for (int n = 1; n <= 9; n++)
            push(n, exp_sd(n, 1, 4'hf, 4'hf));
        for (int n = 10; n <= 13; n++) push(n, exp_rel(n, 10));
        push(14, 11'b000_0000_0001);
        push(15, 11'd0);
        wait_n(3);
        en = 1'b1;
        wait_n(11);
        lock = 1'b0;
        wait_n(13);
        en = 1'b0;
        drain(30);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
